// File: rtl/time_pkg.sv
// ============================================================================
//  Module      : time_pkg
//  Description : Shared field limits, widths and edit-field encoding for the
//                time_adjust_counter block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package time_pkg;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;
    localparam int HOUR_W   = 5;
    localparam int MS_W     = 6;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } edit_field_e;

    // Fixed priority: hour over minute over second.
    function automatic edit_field_e select_field(input logic h_en, input logic m_en,
                                                 input logic s_en);
        if (h_en)      return FIELD_HOUR;
        else if (m_en) return FIELD_MIN;
        else if (s_en) return FIELD_SEC;
        else           return FIELD_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_counter.sv
// ============================================================================
//  Module      : mod_n_counter
//  Description : Modulo-(MAX+1) up/down counter with synchronous load and a
//                combinational wrap pulse on an up-count out of MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_counter #(
    parameter int MAX       = 59,
    parameter int WIDTH     = 6,
    parameter int RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_MAX_VAL   = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_RESET_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_value;

    // up and down together cancel; load wins over counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_value <= c_RESET_VAL;
        end else if (load) begin
            r_value <= load_value;
        end else if (up && !down) begin
            r_value <= (r_value == c_MAX_VAL) ? '0 : r_value + 1'b1;
        end else if (down && !up) begin
            r_value <= (r_value == '0) ? c_MAX_VAL : r_value - 1'b1;
        end
    end

    assign value = r_value;
    assign wrap  = up & ~down & ~load & (r_value == c_MAX_VAL);

endmodule

`default_nettype wire

// File: rtl/time_adjust_counter.sv
// ============================================================================
//  Module      : time_adjust_counter
//  Description : HH:MM:SS timekeeper with run mode (1 Hz ticks with carry)
//                and edit mode (per-field increment without carry).
//                Optional macro TIME_ADJUST_DEC_EN adds a 'dec' input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_adjust_counter
    import time_pkg::*;
#(
    parameter int RESET_HOUR = 0,
    parameter int RESET_MIN  = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_mode,
    input  logic              hour_en,
    input  logic              min_en,
    input  logic              sec_en,
    input  logic              inc,
`ifdef TIME_ADJUST_DEC_EN
    input  logic              dec,
`endif
    input  logic              tick_1hz,
    output logic [HOUR_W-1:0] hour,
    output logic [MS_W-1:0]   min,
    output logic [MS_W-1:0]   sec,
    output logic              day_tick,
    output logic [1:0]        edit_field
);

    edit_field_e w_sel;
    logic        w_inc;
    logic        w_dec;
    logic        w_run_tick;
    logic        w_hour_inc, w_min_inc, w_sec_inc;
    logic        w_hour_dec, w_min_dec, w_sec_dec;
    logic        w_sec_wrap, w_min_wrap, w_hour_wrap;
    logic        w_sec_carry, w_min_carry;

    edit_field_e r_edit_field;
    logic        r_day_tick;

    assign w_sel      = set_mode ? select_field(hour_en, min_en, sec_en) : FIELD_NONE;
    assign w_run_tick = ~set_mode & tick_1hz;

`ifdef TIME_ADJUST_DEC_EN
    assign w_inc = set_mode & inc & ~dec;
    assign w_dec = set_mode & dec & ~inc;
`else
    assign w_inc = set_mode & inc;
    assign w_dec = 1'b0;
`endif

    assign w_hour_inc = w_inc & (w_sel == FIELD_HOUR);
    assign w_min_inc  = w_inc & (w_sel == FIELD_MIN);
    assign w_sec_inc  = w_inc & (w_sel == FIELD_SEC);
    assign w_hour_dec = w_dec & (w_sel == FIELD_HOUR);
    assign w_min_dec  = w_dec & (w_sel == FIELD_MIN);
    assign w_sec_dec  = w_dec & (w_sel == FIELD_SEC);

    // Carries exist only in run mode; edit-mode wraps stay local to a field.
    assign w_sec_carry = ~set_mode & w_sec_wrap;
    assign w_min_carry = ~set_mode & w_min_wrap;

    mod_n_counter #(
        .MAX       (SEC_MAX),
        .WIDTH     (MS_W),
        .RESET_VAL (0)
    ) u_sec (
        .clock      (clock),
        .reset      (reset),
        .load       (w_min_inc),
        .load_value ('0),
        .up         (w_run_tick | w_sec_inc),
        .down       (w_sec_dec),
        .value      (sec),
        .wrap       (w_sec_wrap)
    );

    mod_n_counter #(
        .MAX       (MIN_MAX),
        .WIDTH     (MS_W),
        .RESET_VAL (RESET_MIN)
    ) u_min (
        .clock      (clock),
        .reset      (reset),
        .load       (1'b0),
        .load_value ('0),
        .up         (w_sec_carry | w_min_inc),
        .down       (w_min_dec),
        .value      (min),
        .wrap       (w_min_wrap)
    );

    mod_n_counter #(
        .MAX       (HOUR_MAX),
        .WIDTH     (HOUR_W),
        .RESET_VAL (RESET_HOUR)
    ) u_hour (
        .clock      (clock),
        .reset      (reset),
        .load       (1'b0),
        .load_value ('0),
        .up         (w_min_carry | w_hour_inc),
        .down       (w_hour_dec),
        .value      (hour),
        .wrap       (w_hour_wrap)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_day_tick   <= 1'b0;
            r_edit_field <= FIELD_NONE;
        end else begin
            r_day_tick   <= ~set_mode & w_hour_wrap;
            r_edit_field <= w_sel;
        end
    end

    assign day_tick   = r_day_tick;
    assign edit_field = r_edit_field;

endmodule

`default_nettype wire

// File: tb/tb_time_adjust_counter.sv
// ============================================================================
//  Module      : tb_time_adjust_counter
//  Description : Self-checking bench for time_adjust_counter against a
//                seconds-of-day reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_adjust_counter;

    localparam int RH = 0;
    localparam int RM = 0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       set_mode = 1'b0;
    logic       hour_en = 1'b0;
    logic       min_en = 1'b0;
    logic       sec_en = 1'b0;
    logic       inc = 1'b0;
`ifdef TIME_ADJUST_DEC_EN
    logic       dec = 1'b0;
`endif
    logic       tick_1hz = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       day_tick;
    logic [1:0] edit_field;

    int n_checks = 0;
    int n_err = 0;
    int day_count = 0;

    int exp_h = 0, exp_m = 0, exp_s = 0, exp_d = 0, exp_ef = 0;
    bit model_valid = 1'b0;

    time_adjust_counter #(
        .RESET_HOUR (RH),
        .RESET_MIN  (RM)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .set_mode   (set_mode),
        .hour_en    (hour_en),
        .min_en     (min_en),
        .sec_en     (sec_en),
        .inc        (inc),
`ifdef TIME_ADJUST_DEC_EN
        .dec        (dec),
`endif
        .tick_1hz   (tick_1hz),
        .hour       (hour),
        .min        (min),
        .sec        (sec),
        .day_tick   (day_tick),
        .edit_field (edit_field)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time as seconds-of-day in run mode, per-field modular
    // arithmetic in edit mode.
    always @(posedge clock) begin : model
        int t, nh, nm, ns, nd, f, delta;
        nh = exp_h; nm = exp_m; ns = exp_s; nd = 0;
        f = !set_mode ? 0 : hour_en ? 1 : min_en ? 2 : sec_en ? 3 : 0;
`ifdef TIME_ADJUST_DEC_EN
        delta = int'(inc) - int'(dec);
`else
        delta = int'(inc);
`endif
        if (reset) begin
            nh = RH; nm = RM; ns = 0; f = 0;
        end else if (!set_mode) begin
            if (tick_1hz) begin
                t  = (exp_h * 3600 + exp_m * 60 + exp_s + 1) % 86400;
                nh = t / 3600;
                nm = (t / 60) % 60;
                ns = t % 60;
                nd = (t == 0) ? 1 : 0;
            end
        end else if (delta != 0) begin
            case (f)
                1: nh = (nh + delta + 24) % 24;
                2: begin
                    nm = (nm + delta + 60) % 60;
                    if (delta > 0) ns = 0;
                end
                3: ns = (ns + delta + 60) % 60;
                default: ;
            endcase
        end
        exp_h  <= nh;
        exp_m  <= nm;
        exp_s  <= ns;
        exp_d  <= nd;
        exp_ef <= f;
        if (reset) model_valid <= 1'b1;
    end

    always @(negedge clock) begin
        if (day_tick === 1'b1) day_count++;
        if (model_valid) begin
            cmp("model_hour", int'(hour), exp_h);
            cmp("model_min", int'(min), exp_m);
            cmp("model_sec", int'(sec), exp_s);
            cmp("model_day_tick", int'(day_tick), exp_d);
            cmp("model_edit_field", int'(edit_field), exp_ef);
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic edit(input int field, input int n);
        tick_1hz = 1'b0;
        set_mode = 1'b1;
        hour_en  = (field == 1);
        min_en   = (field == 2);
        sec_en   = (field == 3);
        if (n > 0) begin
            inc = 1'b1;
            run_cycles(n);
            inc = 1'b0;
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        cmp({tag, "_hour"}, int'(hour), h);
        cmp({tag, "_min"}, int'(min), m);
        cmp({tag, "_sec"}, int'(sec), s);
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        run_cycles(2);
        check_time("reset", RH, RM, 0);
        cmp("reset_day_tick", int'(day_tick), 0);
        cmp("reset_edit_field", int'(edit_field), 0);
        reset = 1'b0;

        // 60 ticks in run mode
        tick_1hz = 1'b1;
        run_cycles(60);
        tick_1hz = 1'b0;
        run_cycles(1);
        check_time("run60", 0, 1, 0);
        cmp("run60_no_day_tick", day_count, 0);

        // Preset 23:59:59 then roll over, set_mode falling with the tick
        edit(1, 23);
        edit(2, 58);
        edit(3, 59);
        run_cycles(1);
        check_time("preset", 23, 59, 59);
        cmp("preset_edit_field", int'(edit_field), 3);
        set_mode = 1'b0; sec_en = 1'b0; tick_1hz = 1'b1;
        run_cycles(1);
        check_time("rollover", 0, 0, 0);
        cmp("rollover_day_tick", int'(day_tick), 1);
        tick_1hz = 1'b0;
        run_cycles(1);
        cmp("rollover_day_tick_drop", int'(day_tick), 0);
        cmp("rollover_day_count", day_count, 1);

        // Priority hour over minute, ticks ignored while editing
        edit(1, 22);
        edit(2, 10);
        edit(3, 30);
        set_mode = 1'b1; hour_en = 1'b1; min_en = 1'b1; sec_en = 1'b0;
        tick_1hz = 1'b1; inc = 1'b1;
        run_cycles(3);
        inc = 1'b0; tick_1hz = 1'b1;
        run_cycles(2);
        tick_1hz = 1'b0;
        check_time("prio", 1, 10, 30);
        cmp("prio_edit_field", int'(edit_field), 1);

        // Minute wrap in edit mode: no carry, seconds cleared
        edit(1, 11);
        edit(2, 49);
        edit(3, 41);
        run_cycles(1);
        check_time("pre_minwrap", 12, 59, 41);
        edit(2, 1);
        check_time("minwrap", 12, 0, 0);
        cmp("minwrap_day_count", day_count, 1);

        // Reset mid-edit together with inc
        hour_en = 1'b1; min_en = 1'b0; inc = 1'b1; reset = 1'b1;
        run_cycles(1);
        check_time("reset_edit", RH, RM, 0);
        cmp("reset_edit_field", int'(edit_field), 0);
        reset = 1'b0; inc = 1'b0;
        run_cycles(1);
        check_time("reset_inc_lost", RH, RM, 0);

`ifdef TIME_ADJUST_DEC_EN
        edit(3, 0);
        dec = 1'b1;
        run_cycles(1);
        dec = 1'b0;
        cmp("dec_sec_wrap", int'(sec), 59);
        inc = 1'b1; dec = 1'b1;
        run_cycles(1);
        inc = 1'b0; dec = 1'b0;
        check_time("incdec_nop", RH, RM, 59);
`endif

        // Randomized traffic against the model
        set_mode = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            reset    = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) set_mode = ~set_mode;
            hour_en  = ($urandom_range(0, 3) == 0);
            min_en   = ($urandom_range(0, 2) == 0);
            sec_en   = ($urandom_range(0, 1) == 0);
            inc      = ($urandom_range(0, 2) == 0);
`ifdef TIME_ADJUST_DEC_EN
            dec      = ($urandom_range(0, 3) == 0);
`endif
            tick_1hz = ($urandom_range(0, 1) == 0);
            run_cycles(1);
        end
        reset = 1'b0; inc = 1'b0; tick_1hz = 1'b0;
`ifdef TIME_ADJUST_DEC_EN
        dec = 1'b0;
`endif
        run_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
